// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint sequence checker on the user-project pad bus; deglitches {checkbits,spivalue}, sets sticky pass/fail.
// Optional capture log behind MPRJ_MON_LOG_EN (adds log_addr/log_data).
module mprj_checkpoint_monitor #(
  parameter logic [7:0]              PREFIX         = 8'hA0,
  parameter logic [7:0]              START_CODE     = 8'h40,
  parameter logic [7:0]              PASS_CODE      = 8'h90,
  parameter int                      NUM_CHECKS     = 11,
  parameter logic [8*NUM_CHECKS-1:0] EXPECTED       = 88'h04_12_03_ff_ef_ff_01_02_10_56_04,
  parameter int                      STABLE_CYCLES  = 4,
  parameter int                      TIMEOUT_CYCLES = 25000
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [15:0] checkbits,
  input  logic [7:0]  spivalue,
  output logic        started,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  fail_reason,
  output logic [3:0]  fail_index,
  output logic [7:0]  captured
`ifdef MPRJ_MON_LOG_EN
  ,
  input  logic [3:0]  log_addr,
  output logic [7:0]  log_data
`endif
);

  localparam int              SW     = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SW-1:0]   SLIM   = SW'(STABLE_CYCLES - 1);
  localparam logic [31:0]     TO_LIM = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      NC     = 4'(NUM_CHECKS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t        state;
  logic [23:0]   samp;
  logic [23:0]   last_acc;
  logic [SW-1:0] scnt;
  logic [31:0]   tcnt;
  logic [3:0]    index;

  logic       acc;
  logic       code_hit;
  logic [7:0] code_lo;
  logic [7:0] spi;
  logic [7:0] next_ck;
  logic [7:0] exp_byte;
  logic       timeout;

  // A value is taken once it has been seen STABLE_CYCLES times in a row and is new.
  assign acc      = (scnt == SLIM) && (samp != last_acc);
  assign code_hit = acc && (samp[23:16] == PREFIX);
  assign code_lo  = samp[15:8];
  assign spi      = samp[7:0];
  assign next_ck  = START_CODE + {4'b0000, index} + 8'd1;
  assign exp_byte = 8'(EXPECTED >> {index, 3'b000});
  assign timeout  = (tcnt >= TO_LIM);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      samp     <= '0;
      last_acc <= '0;
      scnt     <= '0;
    end else begin
      samp <= {checkbits, spivalue};
      if ({checkbits, spivalue} == samp) begin
        if (scnt != SLIM) scnt <= scnt + SW'(1);
      end else begin
        scnt <= '0;
      end
      if (acc) last_acc <= samp;
    end
  end

`ifdef MPRJ_MON_LOG_EN
  logic [7:0] log_mem [NUM_CHECKS];
  assign log_data = (log_addr < NC) ? log_mem[log_addr] : 8'h00;
`endif

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      index       <= '0;
      started     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_reason <= '0;
      fail_index  <= '0;
      captured    <= '0;
`ifdef MPRJ_MON_LOG_EN
      for (int i = 0; i < NUM_CHECKS; i++) log_mem[i] <= '0;
`endif
    end else begin
      if ((state == ST_IDLE || state == ST_RUN) && tcnt != '1) tcnt <= tcnt + 32'd1;
      case (state)
        ST_IDLE: begin
          if (code_hit && code_lo == START_CODE) begin
            state   <= ST_RUN;
            started <= 1'b1;
            index   <= '0;
          end else if (!code_hit && timeout) begin
            state       <= ST_FAIL;
            fail        <= 1'b1;
            done        <= 1'b1;
            fail_reason <= 3'd4;
            fail_index  <= index;
          end
        end
        ST_RUN: begin
          // An accepted prefixed code takes precedence over a simultaneous timeout.
          if (code_hit) begin
            if (index < NC && code_lo == next_ck) begin
              captured <= spi;
              index    <= index + 4'd1;
`ifdef MPRJ_MON_LOG_EN
              log_mem[index] <= spi;
`endif
              if (spi != exp_byte) begin
                state       <= ST_FAIL;
                fail        <= 1'b1;
                done        <= 1'b1;
                fail_reason <= 3'd1;
                fail_index  <= index + 4'd1;
              end
            end else if (code_lo == PASS_CODE) begin
              done <= 1'b1;
              if (index == NC) begin
                state <= ST_PASS;
                pass  <= 1'b1;
              end else begin
                state       <= ST_FAIL;
                fail        <= 1'b1;
                fail_reason <= 3'd3;
                fail_index  <= index + 4'd1;
              end
            end else if (code_lo != START_CODE) begin
              state       <= ST_FAIL;
              fail        <= 1'b1;
              done        <= 1'b1;
              fail_reason <= 3'd2;
              fail_index  <= index + 4'd1;
            end
          end else if (timeout) begin
            state       <= ST_FAIL;
            fail        <= 1'b1;
            done        <= 1'b1;
            fail_reason <= 3'd4;
            fail_index  <= index;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Directed bench for mprj_checkpoint_monitor: table of held codes plus hand-written corner sequences.
module tb_mprj_checkpoint_monitor;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] checkbits = '0;
  logic [7:0]  spivalue = '0;
  logic        started, done, pass, fail;
  logic [2:0]  fail_reason;
  logic [3:0]  fail_index;
  logic [7:0]  captured;
`ifdef MPRJ_MON_LOG_EN
  logic [3:0]  log_addr = '0;
  logic [7:0]  log_data;
`endif

  always #5 clock = ~clock;

  mprj_checkpoint_monitor dut (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .spivalue(spivalue),
    .started(started), .done(done), .pass(pass), .fail(fail),
    .fail_reason(fail_reason), .fail_index(fail_index), .captured(captured)
`ifdef MPRJ_MON_LOG_EN
    , .log_addr(log_addr), .log_data(log_data)
`endif
  );

  typedef struct {
    logic        rst;
    logic [15:0] cb;
    logic [7:0]  sv;
    logic        st, pa, fa;
    logic [2:0]  rs;
    logic [3:0]  ix;
    logic [7:0]  cp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] eb [1:11] = '{8'h04, 8'h56, 8'h10, 8'h02, 8'h01, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};

  function automatic void add(logic rst, logic [15:0] cb, logic [7:0] sv, logic st, logic pa,
                              logic fa, logic [2:0] rs, logic [3:0] ix, logic [7:0] cp);
    vec_t v;
    v.rst = rst; v.cb = cb; v.sv = sv; v.st = st; v.pa = pa; v.fa = fa;
    v.rs = rs; v.ix = ix; v.cp = cp;
    vecs.push_back(v);
  endfunction

  function automatic logic [18:0] status();
    return {started, done, pass, fail, fail_reason, fail_index, captured};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic clocks(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    checkbits = '0;
    spivalue  = '0;
    @(negedge clock);
    resetb = 1'b0;
    clocks(2);
    resetb = 1'b1;
    clocks(2);
  endtask

  task automatic drive(logic [15:0] cb, logic [7:0] sv, int n);
    checkbits = cb;
    spivalue  = sv;
    clocks(n);
  endtask

  task automatic run_pass_seq(string nm);
    drive(16'hA040, 8'h00, 10);
    for (int k = 1; k <= 11; k++) drive(16'hA040 + 16'(k), eb[k], 10);
    drive(16'hA090, 8'h00, 10);
    check(nm, 32'(status()), 32'({1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 8'h04}));
  endtask

  initial begin
    // Sequence 1: full good run
    add(1, 16'hA040, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 11; k++) add(0, 16'hA040 + 16'(k), eb[k], 1, 0, 0, 0, 0, eb[k]);
    add(0, 16'hA090, 8'h00, 1, 1, 0, 0, 0, 8'h04);
    // Sequence 2: bad byte at checkpoint 3, later codes ignored
    add(1, 16'hA040, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    add(0, 16'hA041, 8'h04, 1, 0, 0, 0, 0, 8'h04);
    add(0, 16'hA042, 8'h56, 1, 0, 0, 0, 0, 8'h56);
    add(0, 16'hA043, 8'h11, 1, 0, 1, 1, 3, 8'h11);
    add(0, 16'hA044, 8'h02, 1, 0, 1, 1, 3, 8'h11);
    add(0, 16'hA090, 8'h00, 1, 0, 1, 1, 3, 8'h11);
    // Sequence 3: skipped checkpoint
    add(1, 16'hA040, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    add(0, 16'hA041, 8'h04, 1, 0, 0, 0, 0, 8'h04);
    add(0, 16'hA043, 8'h10, 1, 0, 1, 2, 2, 8'h04);
    // Sequence 4: pass code after only five checkpoints
    add(1, 16'hA040, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 5; k++) add(0, 16'hA040 + 16'(k), eb[k], 1, 0, 0, 0, 0, eb[k]);
    add(0, 16'hA090, 8'h00, 1, 0, 1, 3, 6, 8'h01);

    // Reset state, checked while reset is held
    clocks(2);
    check("reset_state", 32'(status()), 32'd0);
    resetb = 1'b1;
    clocks(2);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].cb, vecs[i].sv, 10);
      check($sformatf("vec%0d", i), 32'(status()),
            32'({vecs[i].st, vecs[i].pa | vecs[i].fa, vecs[i].pa, vecs[i].fa,
                 vecs[i].rs, vecs[i].ix, vecs[i].cp}));
    end

    // Filter boundary: three identical samples are not enough, four are
    do_reset();
    drive(16'hA040, 8'h00, 3);
    drive(16'h0000, 8'h00, 10);
    check("stable3_rejected", 32'(started), 32'd0);
    drive(16'hA040, 8'h00, 4);
    drive(16'h0000, 8'h00, 10);
    check("stable4_accepted", 32'(started), 32'd1);

    // Glitch mid-run ignored, then reset mid-run clears everything, then a clean rerun
    do_reset();
    drive(16'hA040, 8'h00, 10);
    for (int k = 1; k <= 2; k++) drive(16'hA040 + 16'(k), eb[k], 10);
    drive(16'h5A5A, 8'h00, 2);
    drive(16'hA043, eb[3], 10);
    drive(16'hA044, eb[4], 10);
    check("glitch_midrun", 32'(status()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h02}));
    resetb = 1'b0;
    #2;
    check("reset_midrun", 32'(status()), 32'd0);
    checkbits = '0;
    clocks(2);
    resetb = 1'b1;
    clocks(2);
    run_pass_seq("rerun_pass");
`ifdef MPRJ_MON_LOG_EN
    log_addr = 4'd1;
    #1;
    check("log_entry1", 32'(log_data), 32'h56);
    log_addr = 4'd10;
    #1;
    check("log_entry10", 32'(log_data), 32'h04);
    log_addr = 4'd14;
    #1;
    check("log_out_of_range", 32'(log_data), 32'h00);
`endif

    // Glitch while idle, then timeout
    begin
      int waited;
      checkbits = '0;
      @(negedge clock);
      resetb = 1'b0;
      clocks(2);
      resetb = 1'b1;
      clocks(5);
      drive(16'h5A5A, 8'h00, 2);
      drive(16'h0000, 8'h00, 24980);
      check("no_early_timeout", 32'(status()), 32'd0);
      waited = 0;
      while (!fail && waited < 200) begin
        @(negedge clock);
        waited++;
      end
      check("timeout_fires", 32'(fail), 32'd1);
      check("timeout_status", 32'(status()), 32'({1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 4'd0, 8'h00}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
